// File: rtl/bram_dual_port_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_dual_port_ext_if
// Purpose  : Per-port access bundle for bram_dual_port_ext (request + response)
// Revision : 1.0 - initial release
// ============================================================================
interface bram_dual_port_ext_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic [NB-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, we, addr, din, input dout, valid);
    modport slave  (input en, we, addr, din, output dout, valid);
endinterface
`default_nettype wire

// File: rtl/bram_dual_port_ext.sv
`default_nettype none
// ============================================================================
// Module   : bram_dual_port_ext
// Purpose  : True dual-port byte-enabled BRAM with collision strobe; define
//            BRAM_INIT_CLEAR_EN to zero the array after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dual_port_ext #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  wire                       clk,
    input  wire                       reset_n,
    bram_dual_port_ext_if.slave       port_a,
    bram_dual_port_ext_if.slave       port_b,
    output logic                      init_busy,
    output logic                      collision
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a;
    logic                  acc_b;
    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic [DATA_WIDTH-1:0] rd_word_a;
    logic [DATA_WIDTH-1:0] rd_word_b;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic                  rv_a;
    logic                  rv_b;

`ifdef BRAM_INIT_CLEAR_EN
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } clr_state_t;

    clr_state_t          state;
    clr_state_t          state_nxt;
    logic [ADDR_WIDTH:0] clr_cnt;
    logic [ADDR_WIDTH:0] clr_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        init_busy   = 1'b0;
        case (state)
            INIT: begin
                init_busy   = 1'b1;
                clr_cnt_nxt = clr_cnt + (ADDR_WIDTH+1)'(1);
                if (clr_cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign clear_we   = init_busy;
    assign clear_addr = clr_cnt[ADDR_WIDTH-1:0];
`else
    assign init_busy  = 1'b0;
    assign clear_we   = 1'b0;
    assign clear_addr = '0;
`endif

    assign acc_a = port_a.en & ~init_busy;
    assign acc_b = port_b.en & ~init_busy;

    // Port B is written first so that port A overrides it on shared lanes.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (acc_b && port_b.we[i]) begin
                    mem[port_b.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_b.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (acc_a && port_a.we[i]) begin
                    mem[port_a.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_a.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first only folds in the port's own lanes; cross-port reads stay old.
    always_comb begin
        rd_word_a = mem[port_a.addr];
        rd_word_b = mem[port_b.addr];
        if (RDW_MODE != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (port_a.we[i]) begin
                    rd_word_a[i*BYTE_WIDTH +: BYTE_WIDTH] = port_a.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (port_b.we[i]) begin
                    rd_word_b[i*BYTE_WIDTH +: BYTE_WIDTH] = port_b.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a      <= '0;
            rd_b      <= '0;
            rv_a      <= 1'b0;
            rv_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            rv_a      <= acc_a;
            rv_b      <= acc_b;
            if (acc_a) rd_a <= rd_word_a;
            if (acc_b) rd_b <= rd_word_b;
            collision <= acc_a & acc_b & (port_a.addr == port_b.addr)
                         & ((|port_a.we) | (|port_b.we));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout_a_q;
            logic [DATA_WIDTH-1:0] dout_b_q;
            logic                  valid_a_q;
            logic                  valid_b_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout_a_q  <= '0;
                    dout_b_q  <= '0;
                    valid_a_q <= 1'b0;
                    valid_b_q <= 1'b0;
                end else begin
                    valid_a_q <= rv_a;
                    valid_b_q <= rv_b;
                    if (rv_a) dout_a_q <= rd_a;
                    if (rv_b) dout_b_q <= rd_b;
                end
            end

            assign port_a.dout  = dout_a_q;
            assign port_b.dout  = dout_b_q;
            assign port_a.valid = valid_a_q;
            assign port_b.valid = valid_b_q;
        end else begin : g_no_out_reg
            assign port_a.dout  = rd_a;
            assign port_b.dout  = rd_b;
            assign port_a.valid = rv_a;
            assign port_b.valid = rv_b;
        end
    endgenerate
endmodule
`default_nettype wire

// File: doc/bram_dual_port_ext.md
# bram_dual_port_ext

Parametrised true dual-port synchronous block RAM and the next generation of the team's dual-port BRAM. Both ports read and write independently with per-byte write enables, a selectable read-during-write mode, an optional output register stage and a registered read-valid strobe. It also detects same-address collisions between the ports and can zero the whole array after reset. It sits between bus-side masters and datapath engines wherever a shared frame, line or coefficient buffer is needed.

## Interface
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- OUT_REG, 0, 1 adds an output pipeline register to both ports
---
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- init_busy  out  1  high while the clear sequence runs; ports are ignored
- en_a / en_b  in  1  port access enable
- we_a / we_b  in  NB  per-lane write enable; ignored unless en is high
- addr_a / addr_b  in  ADDR_WIDTH  word address
- din_a / din_b  in  DATA_WIDTH  write data
- dout_a / dout_b  out  DATA_WIDTH  read data
- valid_a / valid_b  out  1  one-cycle strobe marking dout as updated
- collision  out  1  one-cycle strobe: same-address conflict on the previous access

## Operation
- Access: en high samples addr, we and din. Lanes with we[i]=1 write din[i*BYTE_WIDTH +: BYTE_WIDTH]. Every enabled access, write or not, also reads.
- en low: no memory change; dout holds its value; valid stays 0.
- Same-port read-during-write: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the merged word, with written lanes new and unwritten lanes old.
- Cross-port: a port reading an address the other port writes in the same cycle returns the pre-write word.
- Write-write to the same address: lanes written by both ports take din_a (port A wins). Lanes written by only one port take that port's data.
- collision fires when en_a & en_b, addr_a == addr_b, and (|we_a | |we_b). Two reads to the same address are not a collision.
- Clear FSM has two states:
  - INIT: counter walks addresses 0 to DEPTH-1, writing all-zero words, one per cycle; init_busy=1; en_a/en_b are ignored; valid and collision stay 0.
  - RUN: normal operation. INIT moves to RUN after writing address DEPTH-1.
- The clear counter is ADDR_WIDTH+1 bits wide so the terminal count does not wrap.

## Timing
- Reset values: dout_a/b = 0, valid_a/b = 0, collision = 0, clear counter = 0. init_busy = 1 with the clear feature compiled in, 0 without.
- Read latency from the en-sampling edge: 1 cycle when OUT_REG=0, 2 cycles when OUT_REG=1. valid follows with the same latency.
- collision is registered and asserts 1 cycle after the offending edge, independent of OUT_REG.
- Clear takes exactly DEPTH cycles after reset_n deasserts. The first accepted access is on the edge where init_busy is already 0.
- Back-to-back accesses are allowed every cycle on both ports; throughput is 1 access per port per cycle.
- Reset asserted mid-clear aborts the sequence; after release it restarts from address 0.
- Reset asserted in RUN clears only the registers, not array contents, unless the clear sequence reruns.
- With OUT_REG=1, a pipeline stage holding data when reset asserts is discarded (valid = 0).

## Configuration
- BRAM_INIT_CLEAR_EN defined: the clear FSM is built, the array reads all zeros after the first DEPTH cycles following each reset, and init_busy behaves as above.
- BRAM_INIT_CLEAR_EN undefined: no FSM and no counter. init_busy is tied to 0, the ports are usable on the first edge after reset release, and array contents are undefined until written.

## Test plan
- Clear (macro on, ADDR_WIDTH=3): release reset, then read all 8 addresses on port B → init_busy high for exactly 8 cycles; every dout_b = 0x00 with valid_b pulses.
- Byte lanes (DATA_WIDTH=32): write 0xAABBCCDD, then write we_a=4'b0101 with din 0x11223344 → read returns 0xAA22CC44.
- RDW: write 0x5A to address 2 over old 0x33 on port A → dout_a = 0x33 with RDW_MODE=0, 0x5A with RDW_MODE=1.
- Collision: same edge, port A writes 0x01 to address 4 and port B writes 0x02 to address 4 → collision=1 on the next cycle; later read returns 0x01.
- Cross-port read: port A writes 0x77 to address 5 (old 0x10) while port B reads address 5 → dout_b = 0x10 and collision=1; the next read by port B returns 0x77.
- Latency and reset: OUT_REG=1, back-to-back reads of addresses 0,1,2 → data on cycles +2,+3,+4. Assert reset_n low at the 3rd clear cycle → clear restarts from address 0 and takes 8 cycles after release.
